pipeline_ctrl: RTL and testbench
================================

Name: pipeline_ctrl

Overview:
Central hazard and sequencing controller for the 5-stage RV64I pipeline. It consumes decoded control bits from the ID and EX stages (rs/rd indices, mem_read, reg_write, branch/jal/jalr resolution) and a data-memory ready handshake. It drives per-stage register enables and flushes, the data-memory request, and performance/error counters. It sits beside the decoder and owns all stall/flush policy.

Parameters:
CNT_W, 32, width of the stall and flush performance counters (saturating)
MAX_WAIT, 16, number of consecutive MEM_WAIT cycles that triggers the memory timeout

Ports:
clk  in  1  pipeline clock, all state updates on rising edge
rst  in  1  synchronous, active-high reset
id_rs1  in  5  rs1 index of the instruction in ID
id_rs2  in  5  rs2 index of the instruction in ID
id_uses_rs1  in  1  the ID instruction reads rs1
id_uses_rs2  in  1  the ID instruction reads rs2
ex_rd  in  5  destination index of the instruction in EX
ex_mem_read  in  1  the EX instruction is a load
ex_redirect  in  1  EX has resolved a taken branch, jal or jalr
mem_access  in  1  the MEM-stage instruction is a load or store
dmem_ready  in  1  data memory completes the current access this cycle
pc_en  out  1  PC register update enable
ifid_en  out  1  IF/ID register enable
ifid_flush  out  1  IF/ID loads a bubble (NOP)
idex_en  out  1  ID/EX register enable
idex_flush  out  1  ID/EX loads a bubble (all control bits zero)
exmem_en  out  1  EX/MEM register enable
memwb_bubble  out  1  MEM/WB loads a bubble instead of MEM results
dmem_req  out  1  data memory request
mem_timeout  out  1  sticky error flag, MEM_WAIT exceeded MAX_WAIT
stall_cnt  out  CNT_W  cycles with pc_en low (saturating)
flush_cnt  out  CNT_W  redirect events applied (saturating)

Behaviour:
- The interface has one clock, clk. rst is synchronous and active-high. On rst=1 at a rising edge: state<=RUN, wait_cnt<=0, stall_cnt<=0, flush_cnt<=0, mem_timeout<=0.
- While rst is high, outputs are forced: all enables 0, ifid_flush=1, idex_flush=1, memwb_bubble=1, dmem_req=0.
- All outputs except the counters and mem_timeout are combinational from state and the current inputs, so a hazard takes effect in the same cycle.
- Load-use hazard (lu) = ex_mem_read and ex_rd!=0 and ((id_uses_rs1 and id_rs1==ex_rd) or (id_uses_rs2 and id_rs2==ex_rd)). x0 never causes a hazard.
- FSM has two states, RUN and MEM_WAIT.
- RUN, priority order (highest first):
  1. mem_access and not dmem_ready: freeze. pc_en, ifid_en, idex_en and exmem_en are 0; memwb_bubble=1; dmem_req=1. Next state MEM_WAIT. Any concurrent ex_redirect or lu is held, because EX and ID are frozen, and is applied after release.
  2. ex_redirect: pc_en=1, ifid_flush=1, idex_flush=1, other enables 1. flush_cnt increments. lu is ignored because the ID instruction is squashed.
  3. lu: pc_en=0, ifid_en=0, idex_flush=1, exmem_en=1. This gives exactly 1 bubble per load-use.
  4. Otherwise all enables are 1, no flushes, memwb_bubble=0.
  - In every RUN case, dmem_req=mem_access.
- MEM_WAIT: freeze as in RUN case 1; dmem_req=1; wait_cnt increments each cycle.
  - When dmem_ready=1 in a cycle: the access completes (memwb_bubble=0, stages still frozen that cycle), wait_cnt<=0, next state RUN.
  - When wait_cnt reaches MAX_WAIT-1 without ready: mem_timeout<=1 (sticky until rst) and the FSM stays in MEM_WAIT.
- dmem_ready arriving in the same cycle as a RUN-state mem_access is a zero-wait access: no stall, no state change.
- stall_cnt increments in any cycle with pc_en=0 outside reset. Both counters saturate at all-ones and never wrap.
- A reset asserted mid-MEM_WAIT aborts the access (dmem_req drops in the same cycle) and returns the FSM to RUN.

Test Plan:
- Load-use: ex_mem_read=1, ex_rd=5, id_rs1=5, id_uses_rs1=1 for one cycle -> pc_en=0, ifid_en=0, idex_flush=1 in that cycle; stall_cnt goes 0->1; with ex_rd=0 instead -> no stall.
- Redirect plus load-use in the same cycle (ex_redirect=1, lu true) -> ifid_flush=1, idex_flush=1, pc_en=1, flush_cnt=1, stall_cnt unchanged.
- Memory wait: mem_access=1, dmem_ready low for 3 cycles then high -> dmem_req=1 for 4 cycles, all stage enables low for 4 cycles, memwb_bubble=1 for the first 3 cycles, state RUN on the 5th cycle, stall_cnt=4.
- Redirect held during MEM_WAIT: ex_redirect=1 throughout a 2-cycle wait -> no flush during the wait; ifid_flush=idex_flush=1 on the first RUN cycle; flush_cnt=1.
- Timeout: MAX_WAIT=4, dmem_ready held 0 -> mem_timeout rises after 4 MEM_WAIT cycles and stays 1 after dmem_ready; clears only on rst.
- Reset mid-wait plus saturation: assert rst during MEM_WAIT -> next cycle state RUN, counters 0, dmem_req 0; with CNT_W=4 and 20 stall cycles -> stall_cnt=15.

Source files
------------

// File: rtl/pipeline_ctrl.sv
// Hazard and sequencing controller for the 5-stage RV64I pipeline.
// Owns load-use stalls, redirect flushes, data-memory wait freezing and perf/error counters.
module pipeline_ctrl #(
    parameter int CNT_W    = 32,
    parameter int MAX_WAIT = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic             id_uses_rs1,
    input  logic             id_uses_rs2,
    input  logic [4:0]       ex_rd,
    input  logic             ex_mem_read,
    input  logic             ex_redirect,
    input  logic             mem_access,
    input  logic             dmem_ready,
    output logic             pc_en,
    output logic             ifid_en,
    output logic             ifid_flush,
    output logic             idex_en,
    output logic             idex_flush,
    output logic             exmem_en,
    output logic             memwb_bubble,
    output logic             dmem_req,
    output logic             mem_timeout,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    typedef enum logic {RUN, MEM_WAIT} state_t;

    localparam int WAIT_W = (MAX_WAIT > 1) ? $clog2(MAX_WAIT) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MAX_WAIT - 1);

    state_t            state;
    state_t            state_next;
    logic [WAIT_W-1:0] wait_cnt;
    logic              load_use;
    logic              flush_evt;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + {{(CNT_W-1){1'b0}}, 1'b1};
    endfunction

    // x0 is hardwired to zero, so a load targeting it never creates a dependency.
    assign load_use = ex_mem_read && (ex_rd != 5'd0) &&
                      ((id_uses_rs1 && (id_rs1 == ex_rd)) ||
                       (id_uses_rs2 && (id_rs2 == ex_rd)));

    always_comb begin
        state_next   = state;
        pc_en        = 1'b1;
        ifid_en      = 1'b1;
        ifid_flush   = 1'b0;
        idex_en      = 1'b1;
        idex_flush   = 1'b0;
        exmem_en     = 1'b1;
        memwb_bubble = 1'b0;
        dmem_req     = mem_access;
        flush_evt    = 1'b0;

        if (rst) begin
            pc_en        = 1'b0;
            ifid_en      = 1'b0;
            ifid_flush   = 1'b1;
            idex_en      = 1'b0;
            idex_flush   = 1'b1;
            exmem_en     = 1'b0;
            memwb_bubble = 1'b1;
            dmem_req     = 1'b0;
            state_next   = RUN;
        end else if (state == MEM_WAIT || (mem_access && !dmem_ready)) begin
            // Freeze everything upstream of MEM; pending redirect/lu stay in EX/ID.
            pc_en        = 1'b0;
            ifid_en      = 1'b0;
            idex_en      = 1'b0;
            exmem_en     = 1'b0;
            memwb_bubble = !dmem_ready;
            dmem_req     = 1'b1;
            if (state == RUN) begin
                state_next = MEM_WAIT;
            end else if (dmem_ready) begin
                state_next = RUN;
            end
        end else if (ex_redirect) begin
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
            flush_evt  = 1'b1;
        end else if (load_use) begin
            pc_en      = 1'b0;
            ifid_en    = 1'b0;
            idex_flush = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= RUN;
            wait_cnt    <= '0;
            stall_cnt   <= '0;
            flush_cnt   <= '0;
            mem_timeout <= 1'b0;
        end else begin
            state <= state_next;
            if (state == MEM_WAIT) begin
                if (dmem_ready) begin
                    wait_cnt <= '0;
                end else if (wait_cnt == WAIT_LAST) begin
                    mem_timeout <= 1'b1;
                end else begin
                    wait_cnt <= wait_cnt + 1'b1;
                end
            end
            if (!pc_en) begin
                stall_cnt <= sat_inc(stall_cnt);
            end
            if (flush_evt) begin
                flush_cnt <= sat_inc(flush_cnt);
            end
        end
    end

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Scoreboard bench for pipeline_ctrl: a behavioural model predicts each cycle's outputs,
// a monitor on the falling edge pops and compares against the DUT.
module tb_pipeline_ctrl;

    localparam int CNT_W    = 4;
    localparam int MAX_WAIT = 4;
    localparam int CNT_MAX  = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [4:0]       id_rs1 = '0, id_rs2 = '0, ex_rd = '0;
    logic             id_uses_rs1 = 1'b0, id_uses_rs2 = 1'b0;
    logic             ex_mem_read = 1'b0, ex_redirect = 1'b0;
    logic             mem_access = 1'b0, dmem_ready = 1'b0;
    logic             pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en;
    logic             memwb_bubble, dmem_req, mem_timeout;
    logic [CNT_W-1:0] stall_cnt, flush_cnt;

    pipeline_ctrl #(.CNT_W(CNT_W), .MAX_WAIT(MAX_WAIT)) dut (
        .clk(clk), .rst(rst),
        .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
        .ex_rd(ex_rd), .ex_mem_read(ex_mem_read), .ex_redirect(ex_redirect),
        .mem_access(mem_access), .dmem_ready(dmem_ready),
        .pc_en(pc_en), .ifid_en(ifid_en), .ifid_flush(ifid_flush),
        .idex_en(idex_en), .idex_flush(idex_flush), .exmem_en(exmem_en),
        .memwb_bubble(memwb_bubble), .dmem_req(dmem_req), .mem_timeout(mem_timeout),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en;
        bit memwb_bubble, dmem_req;
        bit regs_known;
        bit mem_timeout;
        int stall_cnt, flush_cnt;
    } exp_t;

    exp_t q[$];
    int   vectors = 0;
    int   miscompares = 0;

    // Reference model state: whether an access is outstanding, how long it has waited,
    // and the counters as unbounded integers clipped to the counter range.
    bit m_known   = 0;
    bit m_waiting = 0;
    int m_waited  = 0;
    bit m_to      = 0;
    int m_stalls  = 0;
    int m_flushes = 0;

    task automatic cyc(input bit r, input bit [4:0] rs1, input bit [4:0] rs2,
                       input bit u1, input bit u2, input bit [4:0] rd, input bit mr,
                       input bit redir, input bit ma, input bit rdy);
        exp_t e;
        bit   lu;
        @(posedge clk);
        #1;
        rst = r; id_rs1 = rs1; id_rs2 = rs2; id_uses_rs1 = u1; id_uses_rs2 = u2;
        ex_rd = rd; ex_mem_read = mr; ex_redirect = redir; mem_access = ma; dmem_ready = rdy;

        lu = mr && rd != 0 && ((u1 && rs1 == rd) || (u2 && rs2 == rd));
        e = '{default: 0};
        e.regs_known  = m_known;
        e.mem_timeout = m_to;
        e.stall_cnt   = m_stalls;
        e.flush_cnt   = m_flushes;
        e.dmem_req    = ma;
        if (r) begin
            e.ifid_flush = 1; e.idex_flush = 1; e.memwb_bubble = 1; e.dmem_req = 0;
            m_known = 1; m_waiting = 0; m_waited = 0; m_to = 0; m_stalls = 0; m_flushes = 0;
        end else begin
            if (m_waiting || (ma && !rdy)) begin
                e.memwb_bubble = !rdy;
                e.dmem_req     = 1;
                if (!m_waiting) begin
                    m_waiting = 1;
                    m_waited  = 0;
                end else if (rdy) begin
                    m_waiting = 0;
                end else begin
                    m_waited++;
                    if (m_waited >= MAX_WAIT) m_to = 1;
                end
            end else if (redir) begin
                e.pc_en = 1; e.ifid_en = 1; e.idex_en = 1; e.exmem_en = 1;
                e.ifid_flush = 1; e.idex_flush = 1;
                if (m_flushes < CNT_MAX) m_flushes++;
            end else if (lu) begin
                e.idex_en = 1; e.idex_flush = 1; e.exmem_en = 1;
            end else begin
                e.pc_en = 1; e.ifid_en = 1; e.idex_en = 1; e.exmem_en = 1;
            end
            if (!e.pc_en && m_stalls < CNT_MAX) m_stalls++;
        end
        q.push_back(e);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic chk(input string name, input int act, input int req);
        if (act != req) begin
            miscompares++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, req);
        end
    endtask

    always @(negedge clk) begin : monitor
        exp_t e;
        if (q.size() > 0) begin
            e = q.pop_front();
            vectors++;
            chk("pc_en", int'(pc_en), int'(e.pc_en));
            chk("ifid_en", int'(ifid_en), int'(e.ifid_en));
            chk("ifid_flush", int'(ifid_flush), int'(e.ifid_flush));
            chk("idex_en", int'(idex_en), int'(e.idex_en));
            chk("idex_flush", int'(idex_flush), int'(e.idex_flush));
            chk("exmem_en", int'(exmem_en), int'(e.exmem_en));
            chk("memwb_bubble", int'(memwb_bubble), int'(e.memwb_bubble));
            chk("dmem_req", int'(dmem_req), int'(e.dmem_req));
            if (e.regs_known) begin
                chk("mem_timeout", int'(mem_timeout), int'(e.mem_timeout));
                chk("stall_cnt", int'(stall_cnt), e.stall_cnt);
                chk("flush_cnt", int'(flush_cnt), e.flush_cnt);
            end
        end
    end

    initial begin
        bit [4:0] rs1, rs2, rd;
        int       drain;
        cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        idle(1);

        // Load-use on rs1, then the same pattern against x0.
        cyc(0, 5, 0, 1, 0, 5, 1, 0, 0, 0);
        cyc(0, 0, 7, 1, 1, 0, 1, 0, 0, 0);
        cyc(0, 3, 9, 0, 1, 9, 1, 0, 0, 0);
        idle(1);

        // Redirect together with a load-use.
        cyc(0, 5, 0, 1, 0, 5, 1, 1, 0, 0);
        idle(1);

        // Three wait cycles then ready, zero-wait access afterwards.
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
        idle(1);

        // Redirect held across a wait, applied on the first free cycle.
        cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        cyc(0, 2, 0, 1, 0, 2, 1, 1, 1, 0);
        cyc(0, 2, 0, 1, 0, 2, 1, 1, 1, 1);
        cyc(0, 2, 0, 1, 0, 2, 1, 1, 0, 0);
        idle(1);

        // Timeout with ready held low, sticky after ready arrives.
        for (int i = 0; i < 7; i++) cyc(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
        idle(3);

        // Reset in the middle of a wait, then stall saturation.
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        cyc(1, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        idle(2);
        for (int i = 0; i < 20; i++) cyc(0, 4, 0, 1, 0, 4, 1, 0, 0, 0);
        for (int i = 0; i < 20; i++) cyc(0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
        idle(1);

        // Randomized traffic with small register indices to provoke hazards.
        for (int i = 0; i < 2000; i++) begin
            rs1 = 5'($urandom_range(0, 3));
            rs2 = 5'($urandom_range(0, 3));
            rd  = 5'($urandom_range(0, 3));
            cyc(($urandom_range(0, 99) < 2), rs1, rs2,
                1'($urandom), 1'($urandom), rd,
                ($urandom_range(0, 99) < 50), ($urandom_range(0, 99) < 15),
                ($urandom_range(0, 99) < 30), ($urandom_range(0, 99) < 45));
        end

        drain = 0;
        while (q.size() > 0 && drain < 5) begin
            @(posedge clk);
            drain++;
        end
        @(posedge clk);
        if (q.size() > 0) begin
            miscompares++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
